// File: rtl/ir_control_fsm.sv
// Control unit for the 8-bit accumulator processor: sequences FETCH/DECODE/execute
// from the IR opcode and drives the datapath, accumulator and memory control lines.
//
// state  | meaning
// -------+-----------------------------------------------------------
// START  | idle after reset, all controls low
// FETCH  | load IR from memory at PC, advance PC
// DECODE | address memory with IR[4:0], branch on opcode
// LOAD   | A <- M[IR[4:0]]
// STORE  | M[IR[4:0]] <- A
// ADD    | A <- A + M[IR[4:0]]
// SUB    | A <- A - M[IR[4:0]]
// INPUT  | wait for Enter, then A <- input port
// JZ     | PC <- IR[4:0] when A == 0
// JPOS   | PC <- IR[4:0] when A >= 0
// HALT   | stopped until reset
module ir_control_fsm #(
  parameter bit ENTER_EDGE = 1'b0
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       PCload,
  output logic       JMPmux,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Outen,
  output logic       Halt,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD   = 4'd3,
    ST_STORE  = 4'd4,
    ST_ADD    = 4'd5,
    ST_SUB    = 4'd6,
    ST_INPUT  = 4'd7,
    ST_JZ     = 4'd8,
    ST_JPOS   = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Plain vector so codes 11-15 remain representable and recoverable.
  logic [3:0] state;
  logic       enter_q;
  logic       go;

  assign go        = ENTER_EDGE ? (Enter & ~enter_q) : Enter;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state   <= ST_START;
      enter_q <= 1'b0;
    end else begin
      enter_q <= Enter;
      case (state)
        ST_START:  state <= ST_FETCH;
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          case (IR)
            3'b000: state <= ST_LOAD;
            3'b001: state <= ST_STORE;
            3'b010: state <= ST_ADD;
            3'b011: state <= ST_SUB;
            3'b100: state <= ST_INPUT;
            3'b101: state <= ST_JZ;
            3'b110: state <= ST_JPOS;
            3'b111: state <= ST_HALT;
          endcase
        end
        ST_LOAD, ST_STORE, ST_ADD, ST_SUB, ST_JZ, ST_JPOS:
          state <= ST_FETCH;
        ST_INPUT:  if (go) state <= ST_FETCH;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_START;
      endcase
    end
  end

  // Controls decode from the current state; reset low masks them immediately.
  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Outen   = 1'b0;
    Halt    = 1'b0;
    if (Reset) begin
      case (state)
        ST_FETCH: begin
          IRload = 1'b1;
          PCload = 1'b1;
        end
        ST_DECODE: Meminst = 1'b1;
        ST_LOAD: begin
          Meminst = 1'b1;
          Asel    = ASEL_MEM;
          Aload   = 1'b1;
        end
        ST_STORE: begin
          Meminst = 1'b1;
          MemWr   = 1'b1;
        end
        ST_ADD: begin
          Meminst = 1'b1;
          Aload   = 1'b1;
        end
        ST_SUB: begin
          Meminst = 1'b1;
          Sub     = 1'b1;
          Aload   = 1'b1;
        end
        ST_INPUT: begin
          Asel  = ASEL_IN;
          Outen = 1'b1;
          Aload = go;
        end
        ST_JZ: begin
          JMPmux = 1'b1;
          PCload = Aeq0;
        end
        ST_JPOS: begin
          JMPmux = 1'b1;
          PCload = Apos;
        end
        ST_HALT: Halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ir_control_fsm.md
Name: ir_control_fsm

Overview:
- Control unit for the 8-bit accumulator processor. It consumes the 3-bit opcode (IR) produced by the IR/PC datapath and the accumulator status flags.
- It drives the datapath control lines: IRload, PCload, JMPmux, Meminst, plus the accumulator and memory controls.
- It sequences START -> FETCH -> DECODE -> execute state per instruction, and holds in HALT until reset.

Parameters:
- ENTER_EDGE, 0, 0: INPUT completes on Enter level high. 1: INPUT completes on a rising edge of Enter, using a registered copy of Enter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- IR  input  3  opcode, Q_IR[7:5] from the IR register.
- Aeq0  input  1  accumulator == 0.
- Apos  input  1  accumulator MSB == 0 (non-negative).
- Enter  input  1  user input-ready strobe.
- IRload  output  1  load IR from memory data.
- PCload  output  1  load PC.
- JMPmux  output  1  PC source: 0 = PC+1, 1 = IR[4:0].
- Meminst  output  1  memory address source: 0 = PC, 1 = IR[4:0].
- MemWr  output  1  write accumulator to memory.
- Asel  output  2  accumulator source: 00 = adder/subtractor, 01 = input port, 10 = memory data, 11 = unused.
- Aload  output  1  load accumulator.
- Sub  output  1  adder performs A - M.
- Outen  output  1  drive accumulator to output port.
- Halt  output  1  processor halted.
- state_dbg  output  4  current state encoding.

Behaviour:
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
- State encodings: START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, JZ=8, JPOS=9, HALT=10. Codes 11-15 are illegal and go to START next cycle with all outputs 0.
- Reset: Reset sampled low at a rising edge -> state = START.
  - All control outputs are forced to 0 combinationally while Reset = 0, regardless of state.
  - The ENTER_EDGE register clears to 0 on reset.
- Outputs decode from the current state, with the listed input qualifiers. Any output not listed for a state is 0.
  - START: all outputs 0. Next: FETCH.
  - FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0. Next: DECODE.
  - DECODE: Meminst=1, so the operand read starts. Next: execute state selected by IR, sampled this cycle.
  - LOAD: Meminst=1, Asel=10, Aload=1. Next: FETCH.
  - STORE: Meminst=1, MemWr=1. Next: FETCH.
  - ADD: Meminst=1, Asel=00, Sub=0, Aload=1. Next: FETCH.
  - SUB: Meminst=1, Asel=00, Sub=1, Aload=1. Next: FETCH.
  - INPUT: Asel=01, Outen=1, Aload=go. Next: FETCH if go, else INPUT.
    - go = Enter when ENTER_EDGE=0.
    - go = Enter & ~Enter_q when ENTER_EDGE=1.
  - JZ: JMPmux=1, PCload=Aeq0. Next: FETCH.
  - JPOS: JMPmux=1, PCload=Apos. Next: FETCH.
  - HALT: Halt=1, all other outputs 0. Next: HALT, left only by reset.
- Latency:
  - First FETCH occurs one cycle after reset release.
  - Non-INPUT instructions take exactly 3 cycles (FETCH, DECODE, execute).
  - INPUT takes 3 + n cycles while waiting.
- Boundary conditions:
  - IR changes during DECODE: the value sampled at the DECODE clock edge decides the branch.
  - IR is ignored in every other state.
  - Enter held high across INPUT entry with ENTER_EDGE=1: no completion until Enter falls and rises again.
  - Aeq0 and Apos both 1 (A=0): JZ and JPOS both take the jump.
  - Reset low in any state, including INPUT wait and HALT: START at the next edge; outputs are 0 immediately.
  - MemWr and Aload are never 1 in the same cycle.
  - IRload is 1 only in FETCH.

Test Plan:
- Reset low 3 cycles then high -> state_dbg sequence 0, 1, 2. IRload=PCload=1 and Meminst=0 only in the FETCH cycle; all outputs 0 while Reset=0.
- IR=000 presented in DECODE -> LOAD (3) for one cycle with Asel=10, Aload=1, Meminst=1, then FETCH. Repeat with IR=011 -> SUB (6) with Sub=1, Aload=1.
- IR=101 with Aeq0=1 -> JZ cycle PCload=1, JMPmux=1. IR=101 with Aeq0=0 -> PCload=0, JMPmux=1. Same pair for IR=110 using Apos.
- IR=100, ENTER_EDGE=0, Enter low 4 cycles then high 1 cycle -> state 7 for 5 cycles, Outen=1 throughout, Aload=1 only in the last cycle, then FETCH. With ENTER_EDGE=1 and Enter already high on entry -> stays in INPUT until the next rising edge of Enter.
- IR=111 -> HALT (10), Halt=1 held for 20 cycles regardless of IR/Enter. Reset low for 1 edge -> START, then FETCH.
- IR=001 with Reset driven low during the STORE cycle -> MemWr forced 0 in that cycle and state START next edge. Force state_dbg to 13 -> START next cycle with all outputs 0.
